// File: rtl/umi_fifo_sync.sv
// Single-clock UMI packet FIFO with occupancy status, flush and bypass.
// Output is first-word-fall-through; ready/valid are gated by reset and flush.
module umi_fifo_sync #(
    parameter     TARGET = "DEFAULT",
    parameter int DEPTH  = 4,
    parameter int UW     = 256,
    parameter int AFULL  = DEPTH - 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          bypass,
    input  logic          flush,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic          fifo_afull,
    output logic [CW-1:0] fifo_count,
    input  logic          umi_in_valid,
    input  logic [UW-1:0] umi_in_packet,
    output logic          umi_in_ready,
    output logic          umi_out_valid,
    output logic [UW-1:0] umi_out_packet,
    input  logic          umi_out_ready,
    input  logic          vdd,
    input  logic          vss
);

    localparam int AW = CW - 1;

    logic [UW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_ready;
    logic          fifo_valid;
    logic          wr;
    logic          rd;
    logic          unused_ok;

    assign unused_ok = vdd ^ vss ^ (TARGET == "DEFAULT");

    // Status is decoded from the registered count only.
    assign fifo_count = count;
    assign fifo_full  = (count == CW'(DEPTH));
    assign fifo_empty = (count == '0);
    assign fifo_afull = (count >= CW'(AFULL));

    assign fifo_ready = ~fifo_full & ~flush & ~reset;
    assign fifo_valid = ~fifo_empty & ~flush & ~reset;

    assign wr = umi_in_valid & fifo_ready & ~bypass;
    assign rd = fifo_valid & umi_out_ready & ~bypass;

    assign umi_in_ready   = bypass ? umi_out_ready : fifo_ready;
    assign umi_out_valid  = bypass ? umi_in_valid  : fifo_valid;
    assign umi_out_packet = bypass ? umi_in_packet : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= umi_in_packet;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (flush && !bypass)) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(wr) - CW'(rd);
        end
    end

endmodule
